// File: rtl/jk_cmd_seq_if.sv
// Command handshake bundle for the JK command sequencer.
// Master offers {CMD_JK, CMD_LEN}; slave answers with CMD_READY.
interface jk_cmd_seq_if #(
    parameter int LEN_W = 4
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_JK;
    logic [LEN_W-1:0] CMD_LEN;

    modport master (
        output CMD_VALID,
        output CMD_JK,
        output CMD_LEN,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_JK,
        input  CMD_LEN,
        output CMD_READY
    );
endinterface

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: 4-deep command FIFO played back onto
// registered J/K drives, each code held for CMD_LEN+1 cycles.
module jk_cmd_seq #(
    parameter int LEN_W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    jk_cmd_seq_if.slave  cmd,
    input  logic         START,
    input  logic         ABORT,
    output logic         J,
    output logic         K,
    output logic         BUSY,
    output logic         DONE,
    output logic [2:0]   LEVEL
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam int EW = LEN_W + 2;

    state_t           state, state_n;
    logic [EW-1:0]    mem [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [LEN_W-1:0] rem;
    logic [EW-1:0]    head;
    logic             push, pop, load, dec, finish;

    assign cmd.CMD_READY = (LEVEL != 3'd4);
    assign BUSY          = (state == RUN);
    assign head          = mem[rd_ptr];
    assign push          = cmd.CMD_VALID && cmd.CMD_READY && !ABORT;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        load    = 1'b0;
        dec     = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (START && LEVEL != 3'd0) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (rem != '0) begin
                    dec = 1'b1;
                end else if (LEVEL != 3'd0) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides every other action in the same cycle.
        if (ABORT) begin
            state_n = IDLE;
            pop     = 1'b0;
            load    = 1'b0;
            dec     = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= {cmd.CMD_JK, cmd.CMD_LEN};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            J      <= 1'b0;
            K      <= 1'b0;
            DONE   <= 1'b0;
            LEVEL  <= 3'd0;
            rem    <= '0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            state <= state_n;
            DONE  <= finish;
            if (ABORT) begin
                J      <= 1'b0;
                K      <= 1'b0;
                LEVEL  <= 3'd0;
                rem    <= '0;
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
            end else begin
                if (load) begin
                    {J, K, rem} <= head;
                end else if (dec) begin
                    rem <= rem - 1'b1;
                end else if (finish) begin
                    J <= 1'b0;
                    K <= 1'b0;
                end
                if (push) wr_ptr <= wr_ptr + 2'd1;
                if (pop)  rd_ptr <= rd_ptr + 2'd1;
                LEVEL <= LEVEL + 3'(push) - 3'(pop);
            end
        end
    end
endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 The block SHALL have one parameter: LEN_W, default 4, the width of the per-command repeat length.
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 CMD_VALID  input  1  command offered this cycle.
REQ-005 CMD_READY  output  1  command queue can accept; high when LEVEL < 4.
REQ-006 CMD_JK  input  2  JK code to drive, {J,K}.
REQ-007 CMD_LEN  input  LEN_W  repeat length; the code is driven for CMD_LEN+1 cycles.
REQ-008 START  input  1  begin playing queued commands; only honoured in IDLE.
REQ-009 ABORT  input  1  stop playback immediately and flush the queue.
REQ-010 J  output  1  registered J drive to the downstream JK flip-flop.
REQ-011 K  output  1  registered K drive to the downstream JK flip-flop.
REQ-012 BUSY  output  1  high while in RUN.
REQ-013 DONE  output  1  one-cycle pulse marking normal completion of the queue.
REQ-014 LEVEL  output  3  number of queued commands, 0..4.

Function
REQ-015 The queue SHALL be a 4-entry FIFO of {CMD_JK, CMD_LEN}, with a push occurring when CMD_VALID && CMD_READY at a rising edge.
REQ-016 CMD_READY SHALL be combinational from LEVEL (LEVEL != 4); CMD_VALID while full SHALL be dropped without a push.
REQ-017 A push and a pop in the same cycle SHALL leave LEVEL unchanged and preserve FIFO order, including when LEVEL = 4 at the start of the cycle only if the pop frees the slot (ready is based on pre-edge LEVEL, so no push at full).
REQ-018 The FSM SHALL have two states: IDLE (J=K=0, BUSY=0) and RUN (BUSY=1).
REQ-019 IDLE->RUN: START=1 and LEVEL>0 at edge t; pop head; J,K = head code and remaining-count = head length from cycle t+1.
REQ-020 START with LEVEL=0, or START while in RUN, SHALL be ignored.
REQ-021 In RUN with remaining-count != 0: decrement and hold J,K.
REQ-022 In RUN with remaining-count = 0 and LEVEL>0: pop next entry and load its code and length at the same edge, with no gap cycle between commands.
REQ-023 In RUN with remaining-count = 0 and LEVEL=0: J,K <= 00, go to IDLE, and DONE=1 for exactly the following cycle.
REQ-024 Commands pushed during RUN SHALL be played in the same run if they arrive before the queue would otherwise drain.
REQ-025 ABORT=1 at any edge (either state) SHALL force J,K <= 00, go to IDLE, set LEVEL <= 0, and not pulse DONE; ABORT takes priority over START, push and pop in that cycle.
REQ-026 A CMD_LEN at its maximum (2^LEN_W-1) SHALL drive for 2^LEN_W cycles without wrap error.
REQ-027 J,K SHALL be driven directly from flops (no combinational path from inputs).

Reset
REQ-028 On RST=1 at an edge: state=IDLE, J=0, K=0, BUSY=0, DONE=0, LEVEL=0, remaining-count=0, FIFO pointers=0; FIFO contents are don't-care.
REQ-029 RST SHALL take priority over ABORT, START and pushes in the same cycle; a RST during RUN SHALL discard the in-progress command.

Verification
REQ-030 Push {01,len 2}, pulse START -> J,K=01 for exactly 3 cycles starting one cycle after START, then 00 with DONE high 1 cycle, BUSY low.
REQ-031 Push {11,0},{10,1},{01,0} then START -> J,K sequence 11,10,10,01,00 back-to-back; DONE coincides with the first 00; LEVEL goes 3,2,1,0.
REQ-032 Push 5 commands with CMD_VALID held high -> CMD_READY low after the 4th; the 5th is not stored; LEVEL=4.
REQ-033 Start {11,len 7}, assert ABORT on the 3rd drive cycle with 2 entries still queued -> next cycle J,K=00, LEVEL=0, BUSY=0, DONE never pulses.
REQ-034 Push while full and popping in the same cycle -> push refused; LEVEL drops by 1; later playback order unchanged.
REQ-035 Assert RST mid-RUN together with START and CMD_VALID -> next cycle all outputs 0, LEVEL=0, and no command is stored.
